// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mul_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_CALC = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_mul_abs.sv
// Combinational two's-complement magnitude; -2^(W-1) maps to 2^(W-1) as unsigned.
module seq_mul_abs #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] val,
  output logic [W-1:0] mag_c,
  output logic         neg_c
);

  assign neg_c = val[W-1];
  assign mag_c = neg_c ? W'(-val) : val;

endmodule

// File: rtl/seq_mul_gen.sv
// Radix-2 shift-add multiplier, signed/unsigned per operation, valid/ready on both
// sides, optional early exit once the remaining multiplier bits are zero.
module seq_mul_gen
  import seq_mul_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sgn,
  input  logic [W-1:0]   mul,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);

  localparam int unsigned P_W   = 2 * W;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [ST_W-1:0]  state, state_nx;
  logic [P_W-1:0]   acc, acc_nx, mcand, mcand_nx, acc_add, prod_nx;
  logic [W-1:0]     mplier, mplier_nx, mplier_sh;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_dec;
  logic             neg, neg_nx, out_valid_nx, in_ready_nx, busy_nx, calc_done;

  logic [W-1:0] mul_mag, b_mag;
  logic         mul_neg, b_neg;

  seq_mul_abs #(.W(W)) u_abs_mul (.val(mul), .mag_c(mul_mag), .neg_c(mul_neg));
  seq_mul_abs #(.W(W)) u_abs_b   (.val(b),   .mag_c(b_mag),   .neg_c(b_neg));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      prod      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      mcand     <= mcand_nx;
      mplier    <= mplier_nx;
      cnt       <= cnt_nx;
      neg       <= neg_nx;
      prod      <= prod_nx;
      out_valid <= out_valid_nx;
      in_ready  <= in_ready_nx;
      busy      <= busy_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    mcand_nx     = mcand;
    mplier_nx    = mplier;
    cnt_nx       = cnt;
    neg_nx       = neg;
    prod_nx      = prod;
    out_valid_nx = out_valid;
    in_ready_nx  = in_ready;
    busy_nx      = busy;

    acc_add   = mplier[0] ? (acc + mcand) : acc;
    mplier_sh = mplier >> 1;
    cnt_dec   = cnt - CNT_W'(1);
    calc_done = (cnt_dec == '0) || (EARLY_EXIT && (mplier_sh == '0));

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          mplier_nx   = sgn ? mul_mag : mul;
          mcand_nx    = {{W{1'b0}}, (sgn ? b_mag : b)};
          neg_nx      = sgn & (mul_neg ^ b_neg);
          acc_nx      = '0;
          cnt_nx      = CNT_W'(W);
          in_ready_nx = 1'b0;
          busy_nx     = 1'b1;
          state_nx    = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_nx    = acc_add;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier_sh;
        cnt_nx    = cnt_dec;
        if (calc_done) begin
          prod_nx      = neg ? P_W'(-acc_add) : acc_add;
          out_valid_nx = 1'b1;
          state_nx     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          busy_nx      = 1'b0;
          state_nx     = ST_IDLE;
        end
      end
      default: begin
        out_valid_nx = 1'b0;
        in_ready_nx  = 1'b1;
        busy_nx      = 1'b0;
        state_nx     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mul_gen.sv
// Scoreboard bench: instance 0 without early exit, instance 1 with early exit,
// both checked against an arithmetic reference model.
module tb_seq_mul_gen;

  typedef struct {
    logic [31:0] p;
    int          e;
  } exp_t;

  logic        clk, reset;
  logic [1:0]  in_valid, in_ready, sgn, out_valid, out_ready, busy;
  logic [15:0] mul [2];
  logic [15:0] b   [2];
  logic [31:0] prod[2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];

  bit          ov_seen[2];
  bit          rdy_was[2];
  int          stall  [2];
  int          nres   [2];
  logic [31:0] cur_prod[2];

  seq_mul_gen #(.W(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sgn(sgn[0]), .mul(mul[0]), .b(b[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .prod(prod[0]), .busy(busy[0]));

  seq_mul_gen #(.W(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sgn(sgn[1]), .mul(mul[1]), .b(b[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .prod(prod[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h (t=%0t)", id, nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_prod(input bit s, input logic [15:0] m, input logic [15:0] bb);
    longint r;
    if (s) r = longint'($signed(m)) * longint'($signed(bb));
    else   r = longint'(m) * longint'(bb);
    return r[31:0];
  endfunction

  function automatic int model_lat(input int id, input bit s, input logic [15:0] m);
    logic [15:0] mag;
    int hi;
    if (id == 0) return 16;
    mag = (s && m[15]) ? 16'(-m) : m;
    hi = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) hi = i + 1;
    return (hi < 1) ? 1 : hi;
  endfunction

  // Present operands, wait for acceptance, then scramble inputs
  task automatic issue(input int id, input bit s, input logic [15:0] m, input logic [15:0] bb, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    sgn[id] = s; mul[id] = m; b[id] = bb; in_valid[id] = 1'b1;
    n = 0;
    while (!in_ready[id] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[id]) begin
      chk(id, "accept_timeout", 64'(in_ready[id]), 64'd1);
      in_valid[id] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[id] = 1'b0;
    chk(id, "busy_after_accept", 64'(busy[id]), 64'd1);
    chk(id, "in_ready_after_accept", 64'(in_ready[id]), 64'd0);
    if (push) begin
      e.p = model_prod(s, m, bb);
      e.e = cyc + model_lat(id, s, m);
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    sgn[id] = 1'($urandom_range(0, 1));
    mul[id] = 16'($urandom);
    b[id]   = 16'($urandom);
  endtask

  // Monitor: pop on rising out_valid, check stability under backpressure
  always @(negedge clk) begin
    exp_t e;
    int   qs;
    if (!reset) begin
      for (int g = 0; g < 2; g++) begin
        if (ov_seen[g] && rdy_was[g]) begin
          chk(g, "valid_after_handshake", 64'(out_valid[g]), 64'd0);
          chk(g, "in_ready_after_handshake", 64'(in_ready[g]), 64'd1);
          ov_seen[g] = 1'b0;
        end
        if (out_valid[g] && !ov_seen[g]) begin
          qs = (g == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            chk(g, "unexpected_result", 64'(qs), 64'd1);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk(g, "prod", 64'(prod[g]), 64'(e.p));
            chk(g, "latency_edge", 64'(cyc), 64'(e.e));
          end
          cur_prod[g] = prod[g];
          ov_seen[g]  = 1'b1;
          stall[g]    = (nres[g] == 0) ? 5 : $urandom_range(0, 6);
          nres[g]++;
        end else if (out_valid[g]) begin
          chk(g, "prod_stable", 64'(prod[g]), 64'(cur_prod[g]));
          chk(g, "in_ready_in_done", 64'(in_ready[g]), 64'd0);
          chk(g, "busy_in_done", 64'(busy[g]), 64'd1);
        end
        rdy_was[g] = 1'b0;
        if (ov_seen[g]) begin
          if (stall[g] == 0) begin
            out_ready[g] = 1'b1;
            rdy_was[g]   = 1'b1;
          end else begin
            out_ready[g] = 1'b0;
            stall[g]--;
          end
        end else begin
          out_ready[g] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic run0();
    issue(0, 1'b0, 16'd17, 16'd16, 1'b1);
    issue(0, 1'b1, 16'hFFFD, 16'd5, 1'b1);
    issue(0, 1'b0, 16'hFFFD, 16'd5, 1'b1);
    issue(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    issue(0, 1'b1, 16'h8000, 16'h8000, 1'b1);
    issue(0, 1'b1, 16'h0000, 16'h8123, 1'b1);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b1);
    end
  endtask

  task automatic run1();
    issue(1, 1'b0, 16'd17, 16'd16, 1'b1);
    issue(1, 1'b0, 16'd0, 16'd123, 1'b1);
    issue(1, 1'b1, 16'hFFFF, 16'd3, 1'b1);
    issue(1, 1'b1, 16'h8000, 16'h8000, 1'b1);
    issue(1, 1'b0, 16'h8000, 16'hFFFF, 1'b1);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1, 1'($urandom_range(0, 1)), 16'(32'($urandom_range(0, 65535)) >> $urandom_range(0, 15)),
            16'($urandom), 1'b1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || ov_seen[0] || ov_seen[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(0, "drain_pending", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0; sgn = '0; out_ready = '0;
    for (int g = 0; g < 2; g++) begin
      mul[g] = '0; b[g] = '0; ov_seen[g] = 1'b0; rdy_was[g] = 1'b0;
      stall[g] = 0; nres[g] = 0; cur_prod[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_out_valid", 64'(out_valid[g]), 64'd0);
      chk(g, "rst_prod", 64'(prod[g]), 64'd0);
      chk(g, "rst_in_ready", 64'(in_ready[g]), 64'd1);
      chk(g, "rst_busy", 64'(busy[g]), 64'd0);
    end
    reset = 1'b0;

    fork
      run0();
      run1();
    join
    drain();

    // Asynchronous reset in the middle of a calculation
    issue(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (7) @(negedge clk);
    chk(0, "busy_before_reset", 64'(busy[0]), 64'd1);
    #1 reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "midrst_out_valid", 64'(out_valid[g]), 64'd0);
      chk(g, "midrst_prod", 64'(prod[g]), 64'd0);
      chk(g, "midrst_in_ready", 64'(in_ready[g]), 64'd1);
      chk(g, "midrst_busy", 64'(busy[g]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(0, 1'b0, 16'd17, 16'd16, 1'b1);
    issue(1, 1'b0, 16'd17, 16'd16, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
